systolic_skew_feeder: RTL and testbench

//  Read side of the per-row weight/input FIFOs that systolic_controller fills via wren_w/wren_i.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/systolic_skew_feeder_lane.sv | 56 +++++
 rtl/systolic_skew_feeder.sv | 131 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic feeder/controller pair.
// Optional build macro used by the feeder: SKEW_FEEDER_PERF_EN.
package systolic_pkg;

    localparam int SYS_ARRAY_SIZE = 16;
    localparam int SYS_DATA_WIDTH = 8;
    localparam int K_LEN_W        = 13;
    localparam int STEP_W         = 14;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Lane `lane` is live for steps lane .. lane+k-1; one extra bit keeps the sum from wrapping.
    function automatic logic in_window(input logic [STEP_W-1:0]  step,
                                       input logic [K_LEN_W-1:0] k,
                                       input int                 lane);
        logic [STEP_W:0] lo;
        logic [STEP_W:0] hi;
        lo = (STEP_W+1)'(lane);
        hi = lo + (STEP_W+1)'(k);
        return ({1'b0, step} >= lo) && ({1'b0, step} < hi);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane.sv
// One feeder lane: skew window test, pop strobe gating and the registered edge data/valid.
module feeder_lane
    import systolic_pkg::*;
#(
    parameter int LANE       = 0,
    parameter int DATA_WIDTH = SYS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  streaming,
    input  logic                  fire,
    input  logic [STEP_W-1:0]     step,
    input  logic [K_LEN_W-1:0]    k_len,
    input  logic                  empty_w,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] q_w,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  ready,
    output logic                  rden_w,
    output logic                  rden_i,
    output logic [DATA_WIDTH-1:0] weight,
    output logic [DATA_WIDTH-1:0] inp,
    output logic                  valid
);

    logic                  active;
    logic                  pop;
    logic [DATA_WIDTH-1:0] w_p1;
    logic [DATA_WIDTH-1:0] i_p1;
    logic                  vld_p1;

    assign active = streaming && in_window(step, k_len, LANE);
    // An idle lane never holds back the global step.
    assign ready  = !active || (!empty_w && !empty_i);
    assign pop    = active && fire;
    assign rden_w = pop;
    assign rden_i = pop;

    // ---- stage p1: FIFO heads captured on pop, zeroed otherwise ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            w_p1   <= '0;
            i_p1   <= '0;
        end else begin
            vld_p1 <= pop;
            w_p1   <= pop ? q_w : '0;
            i_p1   <= pop ? q_i : '0;
        end
    end

    assign weight = w_p1;
    assign inp    = i_p1;
    assign valid  = vld_p1;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed read side of the per-row weight/input FIFOs feeding the systolic array edges.
// Build option: define SKEW_FEEDER_PERF_EN to build the stall_cnt performance counter.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE   = SYS_ARRAY_SIZE,
    parameter int DATA_WIDTH   = SYS_DATA_WIDTH,
    parameter int DRAIN_CYCLES = 2 * ARRAY_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [12:0]                          k_len,
    input  logic [ARRAY_SIZE-1:0]                empty_w,
    input  logic [ARRAY_SIZE-1:0]                empty_i,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] q_w,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] q_i,
    output logic [ARRAY_SIZE-1:0]                rden_w,
    output logic [ARRAY_SIZE-1:0]                rden_i,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] weights,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] inputs,
    output logic [ARRAY_SIZE-1:0]                valid,
    output logic                                 clr,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          stall_cnt
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1) + 1;

    feeder_state_t          state;
    feeder_state_t          state_nx;
    logic [K_LEN_W-1:0]     k_reg;
    logic [STEP_W-1:0]      step;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [ARRAY_SIZE-1:0]  lane_ready;
    logic                   streaming;
    logic                   fire;
    logic                   last_step;
    logic                   drain_done;

    assign streaming  = (state == STREAM);
    // Stalls are global so every lane keeps its diagonal offset.
    assign fire       = streaming && (&lane_ready);
    assign last_step  = (step == STEP_W'(k_reg) + STEP_W'(ARRAY_SIZE - 2));
    // DRAIN's first cycle presents the final popped data; DRAIN_CYCLES more follow it.
    assign drain_done = (drain_cnt == DRAIN_W'(DRAIN_CYCLES));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = (k_len != '0) ? CLEAR : DONE;
            CLEAR:   state_nx = STREAM;
            STREAM:  if (fire && last_step) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_reg     <= '0;
            step      <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE:   if (start && (k_len != '0)) k_reg <= k_len;
                CLEAR: begin
                    step      <= '0;
                    drain_cnt <= '0;
                end
                STREAM: if (fire) step <= step + STEP_W'(1);
                DRAIN:  drain_cnt <= drain_cnt + DRAIN_W'(1);
                default: ;
            endcase
        end
    end

    assign clr  = (state == CLEAR);
    assign busy = (state == CLEAR) || (state == STREAM) || (state == DRAIN);
    assign done = (state == DONE);

    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        feeder_lane #(
            .LANE       (g),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .streaming (streaming),
            .fire      (fire),
            .step      (step),
            .k_len     (k_reg),
            .empty_w   (empty_w[g]),
            .empty_i   (empty_i[g]),
            .q_w       (q_w[g]),
            .q_i       (q_i[g]),
            .ready     (lane_ready[g]),
            .rden_w    (rden_w[g]),
            .rden_i    (rden_i[g]),
            .weight    (weights[g]),
            .inp       (inputs[g]),
            .valid     (valid[g])
        );
    end

`ifdef SKEW_FEEDER_PERF_EN
    logic        stall;
    logic [15:0] stall_q;

    assign stall = streaming && !fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start && (k_len != '0)) begin
            stall_q <= '0;
        end else if (stall && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (ARRAY_SIZE=4, DATA_WIDTH=8, DRAIN_CYCLES=8).
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int DR = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [12:0]         k_len;
    logic [N-1:0]        empty_w;
    logic [N-1:0]        empty_i;
    logic [N-1:0][DW-1:0] q_w;
    logic [N-1:0][DW-1:0] q_i;
    logic [N-1:0]        rden_w;
    logic [N-1:0]        rden_i;
    logic [N-1:0][DW-1:0] weights;
    logic [N-1:0][DW-1:0] inputs;
    logic [N-1:0]        valid;
    logic                clr;
    logic                busy;
    logic                done;
    logic [15:0]         stall_cnt;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .ARRAY_SIZE   (N),
        .DATA_WIDTH   (DW),
        .DRAIN_CYCLES (DR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .empty_w   (empty_w),
        .empty_i   (empty_i),
        .q_w       (q_w),
        .q_i       (q_i),
        .rden_w    (rden_w),
        .rden_i    (rden_i),
        .weights   (weights),
        .inputs    (inputs),
        .valid     (valid),
        .clr       (clr),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    // FIFO model: lane i weight n = 16*i+n, input n = 0x80+16*i+n, counted from base.
    int cnt_w [N] = '{default: 0};
    int cnt_i [N] = '{default: 0};
    int base_w [N] = '{default: 0};
    int base_i [N] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rden_w[i]) cnt_w[i] <= cnt_w[i] + 1;
            if (rden_i[i]) cnt_i[i] <= cnt_i[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            q_w[i] = 8'(16 * i + cnt_w[i] - base_w[i]);
            q_i[i] = 8'(128 + 16 * i + cnt_i[i] - base_i[i]);
        end
    end

    typedef struct {
        logic [3:0] ew;
        logic [3:0] ei;
        logic [3:0] rden;
        logic [3:0] vld;
        logic [7:0] w0;
        logic [7:0] w3;
        logic [7:0] i3;
        logic       clr;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t t1 [22];
    vec_t t2 [22];

    int n_cmp  = 0;
    int n_fail = 0;

    int pops_w [N];
    int pops_i [N];
    int ndone;
    int first_pop;
    int last_pop;
    int done_at;
    int bad_pops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return {rden_w, rden_i, valid, weights[0], weights[3], inputs[3], clr, busy, done};
    endfunction

    function automatic vec_t blank(input logic busy_e);
        vec_t v;
        v.ew = '0; v.ei = '0; v.rden = '0; v.vld = '0;
        v.w0 = '0; v.w3 = '0; v.i3 = '0;
        v.clr = 1'b0; v.busy = busy_e; v.done = 1'b0;
        return v;
    endfunction

    task automatic rebase();
        for (int i = 0; i < N; i++) begin
            base_w[i] = cnt_w[i];
            base_i[i] = cnt_i[i];
        end
    endtask

    task automatic run_table(input string tag, input vec_t t [22], input int n);
        logic [63:0] exp;
        @(negedge clk);
        start = 1'b1;
        k_len = 13'd3;
        for (int c = 0; c < n; c++) begin
            empty_w = t[c].ew;
            empty_i = t[c].ei;
            #1;
            exp = {t[c].rden, t[c].rden, t[c].vld, t[c].w0, t[c].w3, t[c].i3,
                   t[c].clr, t[c].busy, t[c].done};
            check($sformatf("%s_cyc%0d", tag, c), snap(), exp);
            @(negedge clk);
            start = 1'b0;
        end
        empty_w = '0;
        empty_i = '0;
    endtask

    // Runs one tile to completion, optionally re-pulsing start (with another k) at cycle pulse_at.
    task automatic run_tile(input int k, input int pulse_at, input int budget);
        int  c;
        int  tail;
        bit  seen;
        for (int i = 0; i < N; i++) begin
            pops_w[i] = 0;
            pops_i[i] = 0;
        end
        ndone = 0; first_pop = -1; last_pop = -1; done_at = -1; bad_pops = 0;
        c = 0; tail = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = 13'(k);
        while (c < budget && tail < 4) begin
            #1;
            for (int i = 0; i < N; i++) begin
                pops_w[i] += int'(rden_w[i]);
                pops_i[i] += int'(rden_i[i]);
            end
            if (((rden_w & empty_w) != '0) || ((rden_i & empty_i) != '0) || (rden_w != rden_i))
                bad_pops++;
            if (rden_w != '0) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (done) begin
                ndone++;
                done_at = c;
                seen = 1'b1;
            end
            if (seen) tail++;
            @(negedge clk);
            c++;
            start = (pulse_at > 0) && (c == pulse_at);
            if (start) k_len = 13'(k + 2);
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tile_k%0d_timeout: no done within %0d cycles, required done", k, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        empty_w = '0;
        empty_i = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {snap(), stall_cnt}, 64'h0);
        rst = 1'b0;
    endtask

    logic [15:0] exp_stall;

    initial begin
        // Test 1: preloaded FIFOs, k_len=3.
        for (int c = 0; c < 22; c++) t1[c] = blank(c >= 1 && c <= 16);
        t1[1].clr = 1'b1;
        t1[2].rden = 4'h1;
        t1[3].rden = 4'h3; t1[3].vld = 4'h1; t1[3].w0 = 8'h00;
        t1[4].rden = 4'h7; t1[4].vld = 4'h3; t1[4].w0 = 8'h01;
        t1[5].rden = 4'hE; t1[5].vld = 4'h7; t1[5].w0 = 8'h02;
        t1[6].rden = 4'hC; t1[6].vld = 4'hE; t1[6].w3 = 8'h30; t1[6].i3 = 8'hB0;
        t1[7].rden = 4'h8; t1[7].vld = 4'hC; t1[7].w3 = 8'h31; t1[7].i3 = 8'hB1;
        t1[8].vld  = 4'h8; t1[8].w3 = 8'h32; t1[8].i3 = 8'hB2;
        t1[17].done = 1'b1;

        // Test 2: lane 3 empty while still outside its window, then input FIFO 2 empty at s=3.
        for (int c = 0; c < 22; c++) t2[c] = blank(c >= 1 && c <= 19);
        t2[1].clr = 1'b1;
        t2[2].ew = 4'h8; t2[2].rden = 4'h1;
        t2[3].ew = 4'h8; t2[3].rden = 4'h3; t2[3].vld = 4'h1; t2[3].w0 = 8'h00;
        t2[4].ew = 4'h8; t2[4].rden = 4'h7; t2[4].vld = 4'h3; t2[4].w0 = 8'h01;
        t2[5].ei = 4'h4; t2[5].vld = 4'h7; t2[5].w0 = 8'h02;
        t2[6].ei = 4'h4;
        t2[7].ei = 4'h4;
        t2[8].rden  = 4'hE;
        t2[9].rden  = 4'hC; t2[9].vld  = 4'hE; t2[9].w3  = 8'h30; t2[9].i3  = 8'hB0;
        t2[10].rden = 4'h8; t2[10].vld = 4'hC; t2[10].w3 = 8'h31; t2[10].i3 = 8'hB1;
        t2[11].vld  = 4'h8; t2[11].w3 = 8'h32; t2[11].i3 = 8'hB2;
        t2[20].done = 1'b1;

        do_reset();
        rebase();
        run_table("t1", t1, 19);

        rebase();
        run_table("t2", t2, 22);
`ifdef SKEW_FEEDER_PERF_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif
        check("t2_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

        // Test 3: k_len=0 goes straight to DONE.
        @(negedge clk);
        start = 1'b1;
        k_len = 13'd0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t3_cyc%0d", c), {rden_w, rden_i, 2'(clr), 2'(busy), done},
                  {8'h00, 2'b00, 2'b00, (c == 1) ? 1'b1 : 1'b0});
            @(negedge clk);
            start = 1'b0;
        end

        // Test 4: reset in the middle of STREAM, then a fresh k_len=2 tile.
        start = 1'b1;
        k_len = 13'd3;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("t4_streaming_before_rst", 64'(rden_w), 64'h7);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t4_after_rst", {snap(), weights, inputs}, 64'h0);
        rst = 1'b0;
        run_tile(2, 0, 100);
        for (int i = 0; i < N; i++)
            check($sformatf("t4_pops_lane%0d", i), {32'(pops_w[i]), 32'(pops_i[i])}, {32'd2, 32'd2});
        check("t4_done_count", 64'(ndone), 64'd1);

        // Test 5: start pulsed mid-STREAM is ignored.
        run_tile(3, 4, 100);
        for (int i = 0; i < N; i++)
            check($sformatf("t5_pops_lane%0d", i), {32'(pops_w[i]), 32'(pops_i[i])}, {32'd3, 32'd3});
        check("t5_done_count", 64'(ndone), 64'd1);
        check("t5_bad_pops", 64'(bad_pops), 64'd0);

        // Test 6: longest tile, no counter wrap.
        run_tile(8191, 0, 9000);
        for (int i = 0; i < N; i++)
            check($sformatf("t6_pops_lane%0d", i), {32'(pops_w[i]), 32'(pops_i[i])}, {32'd8191, 32'd8191});
        check("t6_stream_len", 64'(last_pop - first_pop + 1), 64'd8194);
        check("t6_drain_to_done", 64'(done_at - last_pop), 64'd10);
        check("t6_done_count", 64'(ndone), 64'd1);
        check("t6_no_stall", 64'(stall_cnt), 64'd0);
        check("t6_idle_after", {2'(busy), 2'(clr), valid}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
